// File: rtl/serial_frame_pkg.sv
// Shared types and constant helpers for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    function automatic int frame_w(input int f, input int k);
        return f - k + 1;
    endfunction

    // Start + data + optional parity + stop, in bit periods.
    function automatic int frame_len(input int w, input bit parity_en);
        return w + (parity_en ? 3 : 2);
    endfunction

endpackage

// File: rtl/serial_frame_shifter.sv
// LSB-first W-bit shift register with a running XOR of every bit shifted in.
module serial_frame_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         d,
    output logic [W-1:0] data,
    output logic         par
);

    logic [W-1:0] data_nxt;

    // First bit received ends up at bit 0 after W shifts.
    generate
        if (W == 1) begin : g_single
            assign data_nxt = d;
        end else begin : g_multi
            assign data_nxt = {d, data[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            par  <= 1'b0;
        end else if (clr) begin
            data <= '0;
            par  <= 1'b0;
        end else if (shift_en) begin
            data <= data_nxt;
            par  <= par ^ d;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, W data bits LSB first, optional even parity,
// stop bit; delivers words on a valid/ready output with one-cycle error pulses.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int F         = 7,
    parameter int K         = 0,
    parameter int PARITY_EN = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       d,
    output logic [F:K] q,
    output logic       q_valid,
    input  logic       q_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overrun
);

    localparam int W  = frame_w(F, K);
    localparam int CW = $clog2(W + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            mismatch;
    logic [W-1:0]    sh_data;
    logic            sh_par;
    logic            sh_clr, sh_en, last_bit;
    logic            good, load, perr_nxt, ferr_nxt;

    serial_frame_shifter #(.W(W)) u_shifter (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (sh_clr),
        .shift_en (sh_en),
        .d        (d),
        .data     (sh_data),
        .par      (sh_par)
    );

    always_comb begin
        state_nxt = state;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        good      = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        last_bit  = (cnt == CW'(W - 1));
        case (state)
            ST_IDLE: begin
                if (!d) begin
                    state_nxt = ST_DATA;
                    sh_clr    = 1'b1;
                end
            end
            ST_DATA: begin
                sh_en = 1'b1;
                if (last_bit)
                    state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
                // A bad stop bit masks any parity mismatch: one pulse per frame.
                if (d) begin
                    good      = !mismatch;
                    perr_nxt  = mismatch;
                    state_nxt = ST_IDLE;
                end else begin
                    ferr_nxt  = 1'b1;
                    state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (d)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        load = good && (!q_valid || q_ready);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            mismatch <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    mismatch <= 1'b0;
                end
                ST_DATA:   if (!last_bit) cnt <= cnt + 1'b1;
                ST_PARITY: mismatch <= d ^ sh_par;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q           <= '0;
            q_valid     <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (load)
                q <= sh_data;
            q_valid     <= load | (q_valid & ~q_ready);
            err_parity  <= perr_nxt;
            err_frame   <= ferr_nxt;
            err_overrun <= good & ~load;
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default 8-bit parity build and a 10-bit
// [12:3] build without parity share the serial line.
module tb_serial_frame_rx;

    logic        clk = 1'b0;
    logic        d, q_ready, rstn_a, rstn_b;
    logic [7:0]  q_a;
    logic [12:3] q_b;
    logic        qv_a, pe_a, fe_a, oe_a;
    logic        qv_b, pe_b, fe_b, oe_b;
    int          n_vec = 0;
    int          n_err = 0;
    logic        sticky;

    always #5 clk = ~clk;

    serial_frame_rx dut_a (
        .clk(clk), .rstn(rstn_a), .d(d), .q(q_a), .q_valid(qv_a), .q_ready(q_ready),
        .err_parity(pe_a), .err_frame(fe_a), .err_overrun(oe_a)
    );

    serial_frame_rx #(.F(12), .K(3), .PARITY_EN(0)) dut_b (
        .clk(clk), .rstn(rstn_b), .d(d), .q(q_b), .q_valid(qv_b), .q_ready(q_ready),
        .err_parity(pe_b), .err_frame(fe_b), .err_overrun(oe_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start bit, data bits LSB first, then parity if enabled; stop bit left to caller.
    task automatic send_body(input logic [31:0] data, input int w, input bit pe, input bit pflip);
        logic p;
        p = 1'b0;
        d = 1'b0;
        tick();
        for (int i = 0; i < w; i++) begin
            d = data[i];
            p = p ^ data[i];
            tick();
        end
        if (pe) begin
            d = p ^ pflip;
            tick();
        end
    endtask

    task automatic idle(input int n);
        d = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        d = 1'b1; q_ready = 1'b0; rstn_a = 1'b0; rstn_b = 1'b0;
        tick(); tick();
        chk("a_rst_q", 32'(q_a), 32'h0);
        chk("a_rst_valid", 32'(qv_a), 32'h0);
        chk("a_rst_errs", {29'b0, pe_a, fe_a, oe_a}, 32'h0);
        rstn_a = 1'b1;
        idle(3);

        // Good frame 0xA5
        send_body(32'hA5, 8, 1'b1, 1'b0);
        chk("a5_valid_before_stop", 32'(qv_a), 32'h0);
        d = 1'b1; tick();
        chk("a5_q", 32'(q_a), 32'hA5);
        chk("a5_valid", 32'(qv_a), 32'h1);
        chk("a5_errs", {29'b0, pe_a, fe_a, oe_a}, 32'h0);
        q_ready = 1'b1; tick(); q_ready = 1'b0;
        chk("a5_consumed", 32'(qv_a), 32'h0);
        idle(2);

        // Parity error
        send_body(32'hA5, 8, 1'b1, 1'b1);
        d = 1'b1; tick();
        chk("perr_pulse", 32'(pe_a), 32'h1);
        chk("perr_valid", 32'(qv_a), 32'h0);
        chk("perr_other", {30'b0, fe_a, oe_a}, 32'h0);
        tick();
        chk("perr_one_cycle", 32'(pe_a), 32'h0);
        idle(2);

        // Bad stop bit with bad parity, then line held low
        send_body(32'hA5, 8, 1'b1, 1'b1);
        d = 1'b0; tick();
        chk("ferr_pulse", 32'(fe_a), 32'h1);
        chk("ferr_masks_perr", 32'(pe_a), 32'h0);
        tick();
        chk("ferr_one_cycle", 32'(fe_a), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        sticky = 1'b0;
        d = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            sticky = sticky | qv_a | pe_a | fe_a | oe_a;
        end
        chk("no_false_frame", 32'(sticky), 32'h0);

        // Back-to-back 0x3C, 0xC3 with q_ready low: overrun
        send_body(32'h3C, 8, 1'b1, 1'b0);
        d = 1'b1; tick();
        chk("b2b_first_q", 32'(q_a), 32'h3C);
        chk("b2b_first_valid", 32'(qv_a), 32'h1);
        send_body(32'hC3, 8, 1'b1, 1'b0);
        d = 1'b1; tick();
        chk("ovr_pulse", 32'(oe_a), 32'h1);
        chk("ovr_q_held", 32'(q_a), 32'h3C);
        chk("ovr_valid", 32'(qv_a), 32'h1);
        tick();
        chk("ovr_one_cycle", 32'(oe_a), 32'h0);
        q_ready = 1'b1; tick(); q_ready = 1'b0;
        chk("ovr_consumed", 32'(qv_a), 32'h0);
        idle(2);

        // Back-to-back with q_ready at second completion
        send_body(32'h3C, 8, 1'b1, 1'b0);
        d = 1'b1; tick();
        send_body(32'hC3, 8, 1'b1, 1'b0);
        d = 1'b1; q_ready = 1'b1; tick(); q_ready = 1'b0;
        chk("rdy_q", 32'(q_a), 32'hC3);
        chk("rdy_valid", 32'(qv_a), 32'h1);
        chk("rdy_no_ovr", 32'(oe_a), 32'h0);
        q_ready = 1'b1; tick(); q_ready = 1'b0;
        idle(2);

        // Parameterised [12:3], no parity
        rstn_b = 1'b1;
        idle(3);
        chk("b_rst_valid", 32'(qv_b), 32'h0);
        send_body(32'h2B7, 10, 1'b0, 1'b0);
        chk("b_valid_before_stop", 32'(qv_b), 32'h0);
        d = 1'b1; tick();
        chk("b_q", 32'(q_b), 32'h2B7);
        chk("b_valid", 32'(qv_b), 32'h1);
        chk("b_errs", {29'b0, pe_b, fe_b, oe_b}, 32'h0);
        idle(2);
        d = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0); tick();
        end
        #2 rstn_b = 1'b0;
        #1;
        chk("b_async_q", 32'(q_b), 32'h0);
        chk("b_async_valid", 32'(qv_b), 32'h0);
        chk("b_async_errs", {29'b0, pe_b, fe_b, oe_b}, 32'h0);
        d = 1'b1;
        tick(); tick();
        rstn_b = 1'b1;
        idle(3);
        chk("b_no_partial", 32'(qv_b), 32'h0);
        send_body(32'h2B7, 10, 1'b0, 1'b0);
        d = 1'b1; tick();
        chk("b_after_rst_q", 32'(q_b), 32'h2B7);
        chk("b_after_rst_valid", 32'(qv_b), 32'h1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
